// File: rtl/mult_sequencer.sv
// mult_sequencer
//   Top-level controller for the unsigned serial multiplier. Accepts a start
//   edge, shifts two serial operands in (LSB first) into parallel registers,
//   pulses the multiplier core, then strobes the 24-bit serial product
//   unloader and tracks its busy flag until the product has left.
//
// Ports
//   clk        in   system clock, rising-edge
//   reset_n    in   asynchronous active-low reset
//   start      in   request level, rising edge acted on in IDLE only
//   x_in/y_in  in   serial operands, LSB first
//   x_par/y_par out captured operands to the multiplier core
//   mult_go    out  one-cycle launch pulse to the core
//   mult_done  in   core product valid (level)
//   sz         out  load strobe to the shift-out block (2 cycles)
//   fz         in   shift-out busy flag
//   busy       out  high in every state except IDLE
//   done       out  one-cycle pulse when the unload is complete
//   err        out  sticky watchdog error
//
// Build option
//   SEQ_TIMEOUT_EN : enables the WAIT_LIMIT watchdog on the three wait
//                    states; without it err is tied low.
//
// state        | meaning
// -------------+----------------------------------------------
// S_IDLE       | waiting for a start edge
// S_SHIFT_IN   | sampling OP_WIDTH serial bits per operand
// S_GO         | mult_go high for this cycle
// S_WAIT_MULT  | waiting for mult_done
// S_LOAD_OUT   | sz high for two cycles
// S_WAIT_FZ_HI | waiting for the unloader to go busy
// S_WAIT_FZ_LO | waiting for the unloader to finish
// S_FINISH     | done high for this cycle

module mult_sequencer #(
  parameter int OP_WIDTH   = 12,
  parameter int WAIT_LIMIT = 64
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                x_in,
  input  logic                y_in,
  output logic [OP_WIDTH-1:0] x_par,
  output logic [OP_WIDTH-1:0] y_par,
  output logic                mult_go,
  input  logic                mult_done,
  output logic                sz,
  input  logic                fz,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int CntW = $clog2(OP_WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT_IN,
    S_GO,
    S_WAIT_MULT,
    S_LOAD_OUT,
    S_WAIT_FZ_HI,
    S_WAIT_FZ_LO,
    S_FINISH
  } state_t;

  state_t              state_q;
  logic [CntW-1:0]     cnt_q;
  logic                load_cnt_q;
  logic                start_q;
  logic                armed_q;
  logic [OP_WIDTH-1:0] x_par_q;
  logic [OP_WIDTH-1:0] y_par_q;
  logic                mult_go_q;
  logic                sz_q;
  logic                busy_q;
  logic                done_q;
  logic                start_edge;

  // armed_q keeps a start level that is already high when reset releases
  // from looking like a fresh edge on the first cycle out of reset.
  assign start_edge = start & ~start_q & armed_q;

`ifdef SEQ_TIMEOUT_EN
  localparam int WdW = $clog2(WAIT_LIMIT + 1);
  logic [WdW-1:0] wd_q;
  logic           err_q;
  logic           wd_expired;
  assign wd_expired = (wd_q == WdW'(WAIT_LIMIT - 1));
  assign err        = err_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^WAIT_LIMIT;
  assign err        = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      load_cnt_q <= 1'b0;
      start_q    <= 1'b0;
      armed_q    <= 1'b0;
      x_par_q    <= '0;
      y_par_q    <= '0;
      mult_go_q  <= 1'b0;
      sz_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      wd_q       <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      start_q   <= start;
      armed_q   <= 1'b1;
      mult_go_q <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_edge) begin
            state_q <= S_SHIFT_IN;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            x_par_q <= '0;
            y_par_q <= '0;
`ifdef SEQ_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
          end
        end
        S_SHIFT_IN: begin
          x_par_q <= {x_in, x_par_q[OP_WIDTH-1:1]};
          y_par_q <= {y_in, y_par_q[OP_WIDTH-1:1]};
          if (cnt_q != CntW'(OP_WIDTH)) cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntW'(OP_WIDTH - 1)) begin
            state_q   <= S_GO;
            mult_go_q <= 1'b1;
          end
        end
        S_GO: begin
          state_q <= S_WAIT_MULT;
`ifdef SEQ_TIMEOUT_EN
          wd_q    <= '0;
`endif
        end
        S_WAIT_MULT: begin
          if (mult_done) begin
            state_q    <= S_LOAD_OUT;
            sz_q       <= 1'b1;
            load_cnt_q <= 1'b0;
          end
`ifdef SEQ_TIMEOUT_EN
          else if (wd_expired) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
`endif
        end
        S_LOAD_OUT: begin
          if (load_cnt_q) begin
            state_q <= S_WAIT_FZ_HI;
            sz_q    <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            wd_q    <= '0;
`endif
          end else begin
            load_cnt_q <= 1'b1;
          end
        end
        S_WAIT_FZ_HI: begin
          if (fz) begin
            state_q <= S_WAIT_FZ_LO;
`ifdef SEQ_TIMEOUT_EN
            wd_q    <= '0;
`endif
          end
`ifdef SEQ_TIMEOUT_EN
          else if (wd_expired) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
`endif
        end
        S_WAIT_FZ_LO: begin
          if (!fz) begin
            state_q <= S_FINISH;
            done_q  <= 1'b1;
          end
`ifdef SEQ_TIMEOUT_EN
          else if (wd_expired) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
`endif
        end
        S_FINISH: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          sz_q    <= 1'b0;
        end
      endcase
    end
  end

  assign x_par   = x_par_q;
  assign y_par   = y_par_q;
  assign mult_go = mult_go_q;
  assign sz      = sz_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
